// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : Opcode encodings and FSM state type shared by the sequential ALU.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Legacy combinational-ALU codes keep their values, zero-extended to 4 bits.
    localparam logic [3:0] c_op_add = 4'h0;
    localparam logic [3:0] c_op_sub = 4'h1;
    localparam logic [3:0] c_op_inc = 4'h2;
    localparam logic [3:0] c_op_dec = 4'h3;
    localparam logic [3:0] c_op_adc = 4'h4;
    localparam logic [3:0] c_op_sbc = 4'h5;
    localparam logic [3:0] c_op_and = 4'h6;
    localparam logic [3:0] c_op_or  = 4'h7;
    localparam logic [3:0] c_op_xor = 4'h8;
    localparam logic [3:0] c_op_shl = 4'h9;
    localparam logic [3:0] c_op_shr = 4'hA;
    localparam logic [3:0] c_op_mul = 4'hB;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Purpose  : Unsigned shift-add multiplier datapath, one partial product/step.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_product,
    output logic                 o_last
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_CNT_W-1:0] r_cnt;

    // Accumulator value after the current step; on the last step this is the product.
    assign o_product = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_last    = (r_cnt == c_CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_cnt    <= c_CNT_W'(WIDTH);
        end else if (i_step) begin
            r_acc    <= o_product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered ALU with carry-chained arithmetic, shifts and a
//            multi-cycle multiply behind a start/ready/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int OP_WIDTH = 4   // must be >= 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OP_WIDTH-1:0] operation,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    output logic                ready,
    output logic                done,
    output logic                err,
    output logic [WIDTH-1:0]    C,
    output logic                flags_c,
    output logic                flags_z
);

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_op_hi_zero;
    logic                 w_legal;
    logic                 w_is_mul;
    logic [WIDTH:0]       w_sum;
    logic                 w_c;
    logic                 w_mul_load;
    logic                 w_mul_step;
    logic                 w_mul_last;
    logic [2*WIDTH-1:0]   w_product;

    generate
        if (OP_WIDTH > 4) begin : g_op_wide
            assign w_op_hi_zero = ~|operation[OP_WIDTH-1:4];
        end else begin : g_op_narrow
            assign w_op_hi_zero = 1'b1;
        end
    endgenerate

    assign ready    = (r_state == ST_IDLE);
    assign w_accept = start & ready;

    // Single-cycle op decode; all arithmetic is WIDTH+1 bits so the top bit is carry/borrow.
    always_comb begin
        w_sum    = '0;
        w_c      = 1'b0;
        w_legal  = w_op_hi_zero;
        w_is_mul = 1'b0;
        case (operation[3:0])
            c_op_add: begin w_sum = {1'b0, A} + {1'b0, B};                      w_c =  w_sum[WIDTH]; end
            c_op_sub: begin w_sum = {1'b0, A} - {1'b0, B};                      w_c = ~w_sum[WIDTH]; end
            c_op_inc: begin w_sum = {1'b0, A} + (WIDTH+1)'(1);                  w_c =  w_sum[WIDTH]; end
            c_op_dec: begin w_sum = {1'b0, A} - (WIDTH+1)'(1);                  w_c = ~w_sum[WIDTH]; end
            c_op_adc: begin w_sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, flags_c};  w_c =  w_sum[WIDTH]; end
            c_op_sbc: begin w_sum = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, ~flags_c}; w_c = ~w_sum[WIDTH]; end
            c_op_and: w_sum = {1'b0, A & B};
            c_op_or:  w_sum = {1'b0, A | B};
            c_op_xor: w_sum = {1'b0, A ^ B};
            c_op_shl: begin w_sum = {1'b0, A[WIDTH-2:0], 1'b0};                 w_c = A[WIDTH-1]; end
            c_op_shr: begin w_sum = {2'b00, A[WIDTH-1:1]};                      w_c = A[0];       end
            c_op_mul: w_is_mul = w_op_hi_zero;
            default:  w_legal  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mul_load   = 1'b0;
        w_mul_step   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_next = ST_MUL;
                    w_mul_load   = 1'b1;
                end
            end
            ST_MUL: begin
                w_mul_step = 1'b1;
                if (w_mul_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_mul_load),
        .i_step    (w_mul_step),
        .i_a       (A),
        .i_b       (B),
        .o_product (w_product),
        .o_last    (w_mul_last)
    );

    // Result/flag registers only move on a completion; illegal opcodes leave them intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            C       <= '0;
            flags_c <= 1'b0;
            flags_z <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (w_accept && !w_is_mul) begin
                done <= 1'b1;
                if (w_legal) begin
                    C       <= w_sum[WIDTH-1:0];
                    flags_c <= w_c;
                    flags_z <= (w_sum[WIDTH-1:0] == '0);
                end else begin
                    err <= 1'b1;
                end
            end else if (w_mul_step && w_mul_last) begin
                done    <= 1'b1;
                C       <= w_product[WIDTH-1:0];
                flags_c <= |w_product[2*WIDTH-1:WIDTH];
                flags_z <= (w_product[WIDTH-1:0] == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq with a queue of expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] operation;
    logic [7:0] A;
    logic [7:0] B;
    logic       ready;
    logic       done;
    logic       err;
    logic [7:0] C;
    logic       flags_c;
    logic       flags_z;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    logic [7:0] m_res = 8'h00;
    logic       m_c   = 1'b0;
    logic       m_z   = 1'b0;

    alu_seq #(
        .WIDTH    (8),
        .OP_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .operation (operation),
        .A         (A),
        .B         (B),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .C         (C),
        .flags_c   (flags_c),
        .flags_z   (flags_z)
    );

    always #5 clk = ~clk;

    // Reference model: integer arithmetic, updates the architectural flag state in issue order.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int   x;
        int   y;
        int   r;
        logic cy;
        exp_t e;
        x = int'(a);
        y = int'(b);
        r = 0;
        cy = 1'b0;
        e.err = 1'b0;
        case (op)
            c_op_add: begin r = x + y;                    cy = (r > 255);  end
            c_op_sub: begin r = x - y;                    cy = (x >= y);   end
            c_op_inc: begin r = x + 1;                    cy = (r > 255);  end
            c_op_dec: begin r = x - 1;                    cy = (x >= 1);   end
            c_op_adc: begin r = x + y + (m_c ? 1 : 0);    cy = (r > 255);  end
            c_op_sbc: begin r = x - y - (m_c ? 0 : 1);    cy = (r >= 0);   end
            c_op_and: r = x & y;
            c_op_or:  r = x | y;
            c_op_xor: r = x ^ y;
            c_op_shl: begin r = x * 2;                    cy = (x >= 128); end
            c_op_shr: begin r = x / 2;                    cy = ((x % 2) == 1); end
            c_op_mul: begin r = x * y;                    cy = (r > 255);  end
            default:  e.err = 1'b1;
        endcase
        if (!e.err) begin
            m_res = 8'(r);
            m_c   = cy;
            m_z   = (m_res == 8'h00);
        end
        e.res = m_res;
        e.c   = m_c;
        e.z   = m_z;
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        start     = 1'b1;
        operation = op;
        A         = a;
        B         = b;
        sb.push_back(model(op, a, b));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        operation = 4'h0;
        A = 8'h00;
        B = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({C, flags_c, flags_z} !== 10'b0)
            $display("FAIL reset_data: got C=%h c=%b z=%b expected 00/0/0", C, flags_c, flags_z);
        else passes++;
        checks++;
        if ({done, err, ready} !== 3'b001)
            $display("FAIL reset_hs: got done=%b err=%b ready=%b expected 0/0/1", done, err, ready);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_add();
        exp_t e;
        @(posedge clk); #1;
        issue(c_op_add, 8'hF0, 8'h20);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || ready !== 1'b1 || err !== 1'b0)
            $display("FAIL add_hs: got done=%b ready=%b err=%b expected 1/1/0", done, ready, err);
        else passes++;
        e = sb.pop_front();
        checks++;
        if ({C, flags_c, flags_z, err} !== e)
            $display("FAIL add_result: got %h/%b/%b expected %h/%b/%b", C, flags_c, flags_z, e.res, e.c, e.z);
        else passes++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0)
            $display("FAIL add_done_pulse: got done=%b expected 0", done);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [2] = '{c_op_sub, c_op_sub};
        logic [7:0] as  [2] = '{8'h05, 8'h03};
        logic [7:0] bs  [2] = '{8'h05, 8'h05};
        exp_t e;
        for (int i = 0; i <= 2; i++) begin
            @(posedge clk); #1;
            if (i < 2) issue(ops[i], as[i], bs[i]);
            else start = 1'b0;
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (done !== 1'b1 || sb.size() == 0) begin
                    $display("FAIL b2b_done[%0d]: got done=%b expected 1", i, done);
                end else begin
                    e = sb.pop_front();
                    if ({C, flags_c, flags_z, err} !== e)
                        $display("FAIL b2b_result[%0d]: got %h/%b/%b/%b expected %h/%b/%b/%b",
                                 i, C, flags_c, flags_z, err, e.res, e.c, e.z, e.err);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_carry_chain();
        logic [3:0] ops [3] = '{c_op_add, c_op_adc, c_op_sbc};
        logic [7:0] as  [3] = '{8'hFF, 8'h01, 8'h05};
        logic [7:0] bs  [3] = '{8'h01, 8'h01, 8'h01};
        exp_t e;
        for (int i = 0; i <= 3; i++) begin
            @(posedge clk); #1;
            if (i < 3) issue(ops[i], as[i], bs[i]);
            else start = 1'b0;
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (done !== 1'b1 || sb.size() == 0) begin
                    $display("FAIL chain_done[%0d]: got done=%b expected 1", i, done);
                end else begin
                    e = sb.pop_front();
                    if ({C, flags_c, flags_z, err} !== e)
                        $display("FAIL chain_result[%0d]: got %h/%b/%b/%b expected %h/%b/%b/%b",
                                 i, C, flags_c, flags_z, err, e.res, e.c, e.z, e.err);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_shift_logic();
        logic [3:0] ops [6] = '{c_op_shl, c_op_shr, c_op_or, c_op_xor, 4'hF, c_op_dec};
        logic [7:0] as  [6] = '{8'h81, 8'h81, 8'h0C, 8'hAA, 8'h12, 8'h00};
        logic [7:0] bs  [6] = '{8'h00, 8'h00, 8'h30, 8'hAA, 8'h34, 8'h00};
        exp_t e;
        for (int i = 0; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i < 6) issue(ops[i], as[i], bs[i]);
            else start = 1'b0;
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (done !== 1'b1 || sb.size() == 0) begin
                    $display("FAIL sl_done[%0d]: got done=%b expected 1", i, done);
                end else begin
                    e = sb.pop_front();
                    if ({C, flags_c, flags_z, err} !== e)
                        $display("FAIL sl_result[%0d]: got %h/%b/%b/%b expected %h/%b/%b/%b",
                                 i, C, flags_c, flags_z, err, e.res, e.c, e.z, e.err);
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_mul(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [9:0] held;
        held = {m_res, m_c, m_z};
        @(posedge clk); #1;
        issue(c_op_mul, a, b);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) begin
                start = 1'b1;
                operation = c_op_add;
                A = 8'h01;
                B = 8'h01;
            end
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || done !== 1'b0 || {C, flags_c, flags_z} !== held)
                $display("FAIL mul_busy[%0d]: got ready=%b done=%b C=%h expected ready=0 done=0 C=%h",
                         k, ready, done, C, held[9:2]);
            else passes++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || ready !== 1'b1 || sb.size() == 0) begin
            $display("FAIL mul_done: got done=%b ready=%b expected 1/1", done, ready);
        end else begin
            e = sb.pop_front();
            if ({C, flags_c, flags_z, err} !== e)
                $display("FAIL mul_result: got %h/%b/%b/%b expected %h/%b/%b/%b",
                         C, flags_c, flags_z, err, e.res, e.c, e.z, e.err);
            else passes++;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0)
            $display("FAIL mul_done_pulse: got done=%b expected 0", done);
        else passes++;
    endtask

    task automatic test_reset_mid_mul();
        exp_t e;
        int   seen;
        @(posedge clk); #1;
        start = 1'b1;
        operation = c_op_mul;
        A = 8'h0F;
        B = 8'h0F;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({C, flags_c, flags_z, ready, done, err} !== 13'b0000000000100)
            $display("FAIL mid_rst: got C=%h c=%b z=%b ready=%b done=%b err=%b expected 00/0/0/1/0/0",
                     C, flags_c, flags_z, ready, done, err);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        m_res = 8'h00;
        m_c = 1'b0;
        m_z = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0)
            $display("FAIL mid_rst_no_done: got %0d done cycles expected 0", seen);
        else passes++;
        @(posedge clk); #1;
        issue(c_op_add, 8'h0F, 8'h01);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || sb.size() == 0) begin
            $display("FAIL post_rst_done: got done=%b expected 1", done);
        end else begin
            e = sb.pop_front();
            if ({C, flags_c, flags_z, err} !== e)
                $display("FAIL post_rst_add: got %h/%b/%b/%b expected %h/%b/%b/%b",
                         C, flags_c, flags_z, err, e.res, e.c, e.z, e.err);
            else passes++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_carry_chain();
        test_shift_logic();
        test_mul(8'h10, 8'h20);
        test_mul(8'h0F, 8'h0F);
        test_reset_mid_mul();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
